// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Shared types and widths for the video path: row-fetch FSM states, row buffer
// address/data widths, SDRAM word address width and row index width, plus the
// helper that forms the SDRAM word address of a word within a display row.
// -----------------------------------------------------------------------------
package video_pkg;

   localparam int BUF_ADDR_W   = 9;
   localparam int BUF_DATA_W   = 16;
   localparam int SDRAM_ADDR_W = 24;
   localparam int ROW_IDX_W    = 11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DATA = 2'd2
   } fetchState_t;

   // base + row*2^shift + word, wrapping modulo 2^SDRAM_ADDR_W.
   function automatic logic [SDRAM_ADDR_W-1:0] rowWordAddr(
      input logic [SDRAM_ADDR_W-1:0] base,
      input logic [ROW_IDX_W-1:0]    row,
      input int                      shift,
      input logic [SDRAM_ADDR_W-1:0] word
   );
      return base + (SDRAM_ADDR_W'(row) << shift) + word;
   endfunction

endpackage

// File: rtl/edge_detect.sv
// -----------------------------------------------------------------------------
// edge_detect
// Registered rising-edge detector for a request level.
// Ports:
//   Clk    - clock
//   Reset  - asynchronous, active-high; clears the history register
//   Level  - request level input
//   Rise   - high in the cycle Level is 1 and was 0 the cycle before
// -----------------------------------------------------------------------------
module edge_detect (
   input  logic Clk,
   input  logic Reset,
   input  logic Level,
   output logic Rise
);

   logic levelQ;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values of the others, regardless of block evaluation order.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) levelQ <= 1'b0;
      else       levelQ <= Level;
   end

   assign Rise = Level & ~levelQ;

endmodule

// File: rtl/row_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// row_fetch_ctrl
// Fetches one display row from SDRAM as a sequence of fixed-length read bursts
// and writes the returned words into the row buffer. A request arriving while a
// fetch is in progress sets the sticky Overrun flag; the newest row wins and
// the current row is abandoned at the next burst boundary.
// Optional feature macro: ROWFETCH_STATS_EN adds the saturating OverrunCount.
// Ports:
//   Clk, Reset             - clock; asynchronous active-high reset
//   GetRow, StartBuffer    - row index and request level from the video side
//   RdReq/RdAddr/RdAck     - SDRAM burst request handshake
//   RdData/RdValid         - SDRAM read data beats
//   BufferAddr/Data/Write  - row buffer write port (registered)
//   Busy                   - fetch in progress or pending
//   Overrun, ClearOverrun  - sticky late-request flag and its clear
//   OverrunCount           - overrun event counter (ROWFETCH_STATS_EN only)
// -----------------------------------------------------------------------------
module row_fetch_ctrl
   import video_pkg::*;
#(
   parameter int                      ROW_WORDS = 512,
   parameter int                      BURST_LEN = 8,
   parameter logic [SDRAM_ADDR_W-1:0] BASE_ADDR = 24'h000000
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic [ROW_IDX_W-1:0]    GetRow,
   input  logic                    StartBuffer,
   output logic                    RdReq,
   output logic [SDRAM_ADDR_W-1:0] RdAddr,
   input  logic                    RdAck,
   input  logic [BUF_DATA_W-1:0]   RdData,
   input  logic                    RdValid,
   output logic [BUF_ADDR_W-1:0]   BufferAddr,
   output logic [BUF_DATA_W-1:0]   BufferData,
   output logic                    BufferWrite,
   output logic                    Busy,
   output logic                    Overrun,
   input  logic                    ClearOverrun
`ifdef ROWFETCH_STATS_EN
   ,
   output logic [15:0]             OverrunCount
`endif
);

   localparam int ROW_SHIFT = $clog2(ROW_WORDS);
   localparam int WCNT_W    = $clog2(ROW_WORDS) + 1;
   localparam int BCNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   fetchState_t          state, nextState;
   logic                 reqEdge;
   logic                 Pend;
   logic [ROW_IDX_W-1:0] PendRow, CurRow;
   logic [WCNT_W-1:0]    WordCnt;
   logic [BCNT_W-1:0]    BeatCnt;
   logic                 lastBeat, rowDone, overrunEv;

   edge_detect uReqEdge (
      .Clk   (Clk),
      .Reset (Reset),
      .Level (StartBuffer),
      .Rise  (reqEdge)
   );

   assign lastBeat  = (state == DATA) && RdValid && (BeatCnt == BCNT_W'(BURST_LEN - 1));
   assign rowDone   = (WordCnt + 1'b1) == WCNT_W'(ROW_WORDS);
   assign RdReq     = (state == REQ);
   // Busy covers the final write strobe so it drops only after the last word
   // has actually landed in the row buffer.
   assign Busy      = (state != IDLE) || Pend || BufferWrite;
   assign overrunEv = reqEdge && Busy;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= nextState;
   end

   // NOTE: nextState gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (Pend) nextState = REQ;
         REQ:     if (RdAck) nextState = DATA;
         // A pending request aborts the row only at a burst boundary; the
         // in-flight burst is always drained first.
         DATA:    if (lastBeat) nextState = (rowDone || Pend) ? IDLE : REQ;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         Pend        <= 1'b0;
         PendRow     <= '0;
         CurRow      <= '0;
         WordCnt     <= '0;
         BeatCnt     <= '0;
         RdAddr      <= '0;
         BufferAddr  <= '0;
         BufferData  <= '0;
         BufferWrite <= 1'b0;
      end else begin
         BufferWrite <= 1'b0;
         if (reqEdge) PendRow <= GetRow;
         // A new edge in the same cycle IDLE consumes Pend keeps it set.
         if (reqEdge)            Pend <= 1'b1;
         else if (state == IDLE) Pend <= 1'b0;

         case (state)
            IDLE: begin
               if (Pend) begin
                  CurRow  <= PendRow;
                  WordCnt <= '0;
                  RdAddr  <= rowWordAddr(BASE_ADDR, PendRow, ROW_SHIFT, '0);
               end
            end
            REQ: begin
               if (RdAck) BeatCnt <= '0;
            end
            DATA: begin
               if (RdValid) begin
                  BufferWrite <= 1'b1;
                  BufferAddr  <= BUF_ADDR_W'(WordCnt);
                  BufferData  <= RdData;
                  WordCnt     <= WordCnt + 1'b1;
                  BeatCnt     <= BeatCnt + 1'b1;
                  if (lastBeat)
                     RdAddr <= rowWordAddr(BASE_ADDR, CurRow, ROW_SHIFT,
                                           SDRAM_ADDR_W'(WordCnt + 1'b1));
               end
            end
            default: ;
         endcase
      end
   end

   // Set has priority over clear so a simultaneous late request is never lost.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)             Overrun <= 1'b0;
      else if (overrunEv)    Overrun <= 1'b1;
      else if (ClearOverrun) Overrun <= 1'b0;
   end

`ifdef ROWFETCH_STATS_EN
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         OverrunCount <= '0;
      end else if (overrunEv) begin
         if (OverrunCount != 16'hFFFF) OverrunCount <= OverrunCount + 16'd1;
      end else if (ClearOverrun) begin
         OverrunCount <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_row_fetch_ctrl.sv
`timescale 1ns/1ps
module tb_row_fetch_ctrl;
   import video_pkg::*;

   localparam int ROW_WORDS = 512;
   localparam int BURST_LEN = 8;

   typedef struct packed {
      logic [8:0]  addr;
      logic [15:0] data;
   } wr_t;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [10:0] GetRow;
   logic        StartBuffer;
   logic        RdReq;
   logic [23:0] RdAddr;
   logic        RdAck;
   logic [15:0] RdData;
   logic        RdValid;
   logic [8:0]  BufferAddr;
   logic [15:0] BufferData;
   logic        BufferWrite;
   logic        Busy;
   logic        Overrun;
   logic        ClearOverrun;
`ifdef ROWFETCH_STATS_EN
   logic [15:0] OverrunCount;
   logic [15:0] wOverrunCount;
`endif

   // Second instance with a base address near the top of the SDRAM space.
   logic [10:0] wGetRow;
   logic        wStartBuffer;
   logic        wRdAck, wRdValid, wClearOverrun;
   logic [15:0] wRdData;
   logic        wRdReq, wBufferWrite, wBusy, wOverrun;
   logic [23:0] wRdAddr;
   logic [8:0]  wBufferAddr;
   logic [15:0] wBufferData;

   always #5 Clk = ~Clk;

   row_fetch_ctrl #(.ROW_WORDS(ROW_WORDS), .BURST_LEN(BURST_LEN), .BASE_ADDR(24'h000000)) dut (
      .Clk(Clk), .Reset(Reset), .GetRow(GetRow), .StartBuffer(StartBuffer),
      .RdReq(RdReq), .RdAddr(RdAddr), .RdAck(RdAck), .RdData(RdData), .RdValid(RdValid),
      .BufferAddr(BufferAddr), .BufferData(BufferData), .BufferWrite(BufferWrite),
      .Busy(Busy), .Overrun(Overrun), .ClearOverrun(ClearOverrun)
`ifdef ROWFETCH_STATS_EN
      , .OverrunCount(OverrunCount)
`endif
   );

   row_fetch_ctrl #(.ROW_WORDS(ROW_WORDS), .BURST_LEN(BURST_LEN), .BASE_ADDR(24'hFFFE00)) wDut (
      .Clk(Clk), .Reset(Reset), .GetRow(wGetRow), .StartBuffer(wStartBuffer),
      .RdReq(wRdReq), .RdAddr(wRdAddr), .RdAck(wRdAck), .RdData(wRdData), .RdValid(wRdValid),
      .BufferAddr(wBufferAddr), .BufferData(wBufferData), .BufferWrite(wBufferWrite),
      .Busy(wBusy), .Overrun(wOverrun), .ClearOverrun(wClearOverrun)
`ifdef ROWFETCH_STATS_EN
      , .OverrunCount(wOverrunCount)
`endif
   );

   int nAsserts = 0;
   int nFails   = 0;

   wr_t         expWr[$];
   logic [23:0] expBurst[$];

   // SDRAM model state
   int          ackDelay = 0;
   int          gapPct   = 0;
   int          waitCnt  = 0;
   int          beatsLeft = 0;
   int          strayLeft = 0;
   int          ackCount = 0;
   bit          ackedLast = 0;
   logic [23:0] mAddr, reqAddr;

   // Expected bursts and buffer writes for the first nBursts bursts of a row
   // (BASE_ADDR 0; the SDRAM model returns address[15:0] as data).
   task automatic pushRow(input int row, input int nBursts);
      logic [23:0] a;
      for (int b = 0; b < nBursts; b++) begin
         expBurst.push_back(24'(row * ROW_WORDS + b * BURST_LEN));
         for (int i = 0; i < BURST_LEN; i++) begin
            a = 24'(row * ROW_WORDS + b * BURST_LEN + i);
            expWr.push_back({9'(b * BURST_LEN + i), a[15:0]});
         end
      end
   endtask

   // One clock: scoreboard the row-buffer port, then run the SDRAM model.
   task automatic tick();
      wr_t         e;
      logic [23:0] eb;
      @(negedge Clk);
      if (BufferWrite === 1'b1) begin
         nAsserts++;
         if (expWr.size() == 0) begin
            nFails++;
            $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", BufferAddr, BufferData);
         end else begin
            e = expWr.pop_front();
            if ({BufferAddr, BufferData} !== e) begin
               nFails++;
               $display("FAIL buffer_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                        BufferAddr, BufferData, e.addr, e.data);
            end
         end
      end
      if (ackedLast) begin
         ackedLast = 0;
         nAsserts++;
         if (RdReq !== 1'b0) begin
            nFails++;
            $display("FAIL rdreq_drop: got RdReq=%b after ack, expected 0", RdReq);
         end
      end
      RdAck   = 1'b0;
      RdValid = 1'b0;
      RdData  = 16'h0000;
      if (Reset) begin
         beatsLeft = 0;
         waitCnt   = 0;
      end else if (beatsLeft > 0) begin
         if ($urandom_range(99) >= gapPct) begin
            RdValid   = 1'b1;
            RdData    = mAddr[15:0];
            mAddr     = mAddr + 24'd1;
            beatsLeft = beatsLeft - 1;
         end
      end else if (strayLeft > 0) begin
         RdValid   = 1'b1;
         RdData    = 16'hBEEF;
         strayLeft = strayLeft - 1;
      end else if (RdReq === 1'b1) begin
         if (waitCnt == 0) begin
            reqAddr = RdAddr;
         end else begin
            nAsserts++;
            if (RdAddr !== reqAddr) begin
               nFails++;
               $display("FAIL rdaddr_stable: got %h while RdReq held, expected %h", RdAddr, reqAddr);
            end
         end
         if (waitCnt >= ackDelay) begin
            RdAck     = 1'b1;
            waitCnt   = 0;
            ackCount  = ackCount + 1;
            ackedLast = 1;
            mAddr     = RdAddr;
            beatsLeft = BURST_LEN;
            nAsserts++;
            if (expBurst.size() == 0) begin
               nFails++;
               $display("FAIL unexpected_burst: got RdAddr=%h, expected no burst", RdAddr);
            end else begin
               eb = expBurst.pop_front();
               if (RdAddr !== eb) begin
                  nFails++;
                  $display("FAIL burst_addr: got %h, expected %h", RdAddr, eb);
               end
            end
         end else begin
            waitCnt++;
         end
      end
   endtask

   task automatic reqRow(input logic [10:0] row);
      GetRow      = row;
      StartBuffer = 1'b1;
      tick();
      StartBuffer = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 6000 && (expWr.size() > 0 || expBurst.size() > 0 || Busy); i++) tick();
      nAsserts++;
      if (expWr.size() > 0 || expBurst.size() > 0 || Busy !== 1'b0) begin
         nFails++;
         $display("FAIL %s_drain: got %0d writes/%0d bursts left Busy=%b, expected 0/0/0",
                  name, expWr.size(), expBurst.size(), Busy);
      end
   endtask

   task automatic waitAcks(input int tgt, input string name);
      for (int i = 0; i < 3000 && ackCount < tgt; i++) tick();
      nAsserts++;
      if (ackCount < tgt) begin
         nFails++;
         $display("FAIL %s_ack_timeout: got %0d acks, expected %0d", name, ackCount, tgt);
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1; GetRow = '0; StartBuffer = 1'b0; RdAck = 1'b0; RdValid = 1'b0;
      RdData = '0; ClearOverrun = 1'b0;
      wGetRow = '0; wStartBuffer = 1'b0; wRdAck = 1'b0; wRdValid = 1'b0; wRdData = '0;
      wClearOverrun = 1'b0;
      tick(); tick();
      nAsserts++;
      if ({RdReq, RdAddr, BufferAddr, BufferData, BufferWrite, Busy, Overrun} !== '0) begin
         nFails++;
         $display("FAIL reset_outputs: got RdReq=%b RdAddr=%h BA=%h BD=%h BW=%b Busy=%b Ovr=%b, expected all 0",
                  RdReq, RdAddr, BufferAddr, BufferData, BufferWrite, Busy, Overrun);
      end
`ifdef ROWFETCH_STATS_EN
      nAsserts++;
      if (OverrunCount !== 16'd0) begin
         nFails++;
         $display("FAIL reset_count: got %0d, expected 0", OverrunCount);
      end
`endif
      Reset = 1'b0;
      tick();
   endtask

   task automatic test_single_row();
      pushRow(5, 64);
      GetRow = 11'd5; StartBuffer = 1'b1;
      tick();
      StartBuffer = 1'b0;
      nAsserts++;
      if (RdReq !== 1'b0 || Busy !== 1'b1) begin
         nFails++;
         $display("FAIL req_latency_n1: got RdReq=%b Busy=%b, expected 0 1", RdReq, Busy);
      end
      tick();
      nAsserts++;
      if (RdReq !== 1'b1 || RdAddr !== 24'h000A00) begin
         nFails++;
         $display("FAIL req_latency_n2: got RdReq=%b RdAddr=%h, expected 1 000a00", RdReq, RdAddr);
      end
      for (int i = 0; i < 6000 && expWr.size() > 0; i++) tick();
      nAsserts++;
      if (expWr.size() > 0 || Busy !== 1'b1) begin
         nFails++;
         $display("FAIL single_last_write: got %0d writes left Busy=%b, expected 0 1", expWr.size(), Busy);
      end
      tick();
      nAsserts++;
      if (Busy !== 1'b0 || expBurst.size() != 0 || Overrun !== 1'b0) begin
         nFails++;
         $display("FAIL single_done: got Busy=%b bursts_left=%0d Overrun=%b, expected 0 0 0",
                  Busy, expBurst.size(), Overrun);
      end
   endtask

   task automatic test_gaps();
      ackDelay = 3; gapPct = 30;
      pushRow(5, 64);
      reqRow(11'd5);
      drain("gaps");
      ackDelay = 0; gapPct = 0;
      nAsserts++;
      if (Overrun !== 1'b0) begin
         nFails++;
         $display("FAIL gaps_overrun: got %b, expected 0", Overrun);
      end
   endtask

   task automatic test_overrun();
      int tgt;
      pushRow(7, 4);
      pushRow(9, 64);
      tgt = ackCount + 4;
      reqRow(11'd7);
      waitAcks(tgt, "overrun");
      reqRow(11'd9);
      nAsserts++;
      if (Overrun !== 1'b1) begin
         nFails++;
         $display("FAIL overrun_set: got %b, expected 1", Overrun);
      end
`ifdef ROWFETCH_STATS_EN
      nAsserts++;
      if (OverrunCount !== 16'd1) begin
         nFails++;
         $display("FAIL overrun_count: got %0d, expected 1", OverrunCount);
      end
`endif
      drain("overrun");
      nAsserts++;
      if (Overrun !== 1'b1) begin
         nFails++;
         $display("FAIL overrun_sticky: got %b, expected 1", Overrun);
      end
   endtask

   task automatic test_clear_vs_set();
      int tgt;
      pushRow(2, 1);
      pushRow(3, 64);
      tgt = ackCount + 1;
      reqRow(11'd2);
      waitAcks(tgt, "clrset");
      GetRow = 11'd3; StartBuffer = 1'b1; ClearOverrun = 1'b1;
      tick();
      StartBuffer = 1'b0; ClearOverrun = 1'b0;
      nAsserts++;
      if (Overrun !== 1'b1) begin
         nFails++;
         $display("FAIL clear_vs_set: got Overrun=%b, expected 1", Overrun);
      end
`ifdef ROWFETCH_STATS_EN
      nAsserts++;
      if (OverrunCount !== 16'd2) begin
         nFails++;
         $display("FAIL clear_vs_set_count: got %0d, expected 2", OverrunCount);
      end
`endif
      drain("clrset");
      ClearOverrun = 1'b1;
      tick();
      ClearOverrun = 1'b0;
      nAsserts++;
      if (Overrun !== 1'b0) begin
         nFails++;
         $display("FAIL clear_alone: got Overrun=%b, expected 0", Overrun);
      end
`ifdef ROWFETCH_STATS_EN
      nAsserts++;
      if (OverrunCount !== 16'd0) begin
         nFails++;
         $display("FAIL clear_alone_count: got %0d, expected 0", OverrunCount);
      end
`endif
   endtask

   task automatic test_reset_mid();
      int tgt;
      pushRow(4, 11);
      tgt = ackCount + 11;
      reqRow(11'd4);
      waitAcks(tgt, "rstmid");
      tick(); tick(); tick();
      Reset = 1'b1;
      #1;
      nAsserts++;
      if ({RdReq, RdAddr, BufferAddr, BufferData, BufferWrite, Busy, Overrun} !== '0) begin
         nFails++;
         $display("FAIL reset_mid_outputs: got RdReq=%b RdAddr=%h BA=%h BD=%h BW=%b Busy=%b Ovr=%b, expected all 0",
                  RdReq, RdAddr, BufferAddr, BufferData, BufferWrite, Busy, Overrun);
      end
      expWr.delete();
      expBurst.delete();
      tick(); tick();
      Reset = 1'b0;
      strayLeft = 4;
      for (int i = 0; i < 6; i++) tick();
      nAsserts++;
      if (BufferWrite !== 1'b0 || Busy !== 1'b0 || RdReq !== 1'b0) begin
         nFails++;
         $display("FAIL stray_data: got BW=%b Busy=%b RdReq=%b, expected 0 0 0", BufferWrite, Busy, RdReq);
      end
      pushRow(6, 64);
      reqRow(11'd6);
      drain("after_reset");
   endtask

   task automatic test_wrap();
      wGetRow = 11'd1; wStartBuffer = 1'b1;
      tick();
      wStartBuffer = 1'b0;
      for (int i = 0; i < 8 && wRdReq !== 1'b1; i++) tick();
      nAsserts++;
      if (wRdReq !== 1'b1 || wRdAddr !== 24'h000000 || wBusy !== 1'b1) begin
         nFails++;
         $display("FAIL addr_wrap: got RdReq=%b RdAddr=%h Busy=%b, expected 1 000000 1", wRdReq, wRdAddr, wBusy);
      end
   endtask

   initial begin
      test_reset();
      test_single_row();
      test_gaps();
      test_overrun();
      test_clear_vs_set();
      test_reset_mid();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
